multicycle_cpu: RTL and testbench
=================================

Name: multicycle_cpu

Overview:
- Parametrised multi-cycle successor of the single-cycle 16-bit CPU core.
- Fetches, executes, accesses memory and writes back over several clocks through one shared memory port.
- Uses a proper readM/writeM/inputReady handshake, with wait states allowed on every access.
- Adds a registered output port, a halt state, and a generalised datapath width and register count.

Parameters:
- WORD_SIZE, 16, datapath/address/register width; must be >= 16; instruction always occupies data_in[15:0].
- NUM_REGS, 4, number of general registers; register fields are 2 bits, so only 2 or 4 is legal.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  synchronous active-low reset.
- readM  output  1  memory read request.
- writeM  output  1  memory write request.
- address  output  WORD_SIZE  memory address.
- data_out  output  WORD_SIZE  write data; 0 when writeM=0.
- data_in  input  WORD_SIZE  read data; valid on the edge where inputReady=1.
- inputReady  input  1  memory completes the current request this edge.
- num_inst  output  WORD_SIZE  count of retired instructions.
- output_port  output  WORD_SIZE  last value written by WWD.
- halted  output  1  core is in HALT.

Behaviour:
- Reset: sampled at posedge when reset_n=0.
  - PC=RESET_PC, all registers 0, num_inst=0, output_port=0, halted=0, state=IF.
  - readM, writeM, address and data_out are forced to 0 while reset_n=0.
  - Reset in any state (including mid-handshake) abandons the access; no register, PC or count update occurs.
- Encoding (16 bits):
  - op[15:12], rs[11:10], rt[9:8], rd[7:6], func[5:0], imm8[7:0], tgt[11:0].
  - simm = imm8 sign-extended to WORD_SIZE; zimm = imm8 zero-extended.
- Opcodes:
  - 0 ADI: rt=rs+simm.
  - 1 ORI: rt=rs|zimm.
  - 2 LHI: rt=zimm<<8.
  - 3 R-type, by func:
    - 0 ADD, 1 SUB (rs-rt), 2 AND, 3 ORR: rd=rs op rt.
    - 4 NOT: rd=~rs.
    - 5 TCP: rd=-rs.
    - 6 SHL: rd=rs<<1.
    - 7 SHR: rd=rs>>>1, arithmetic.
    - 28 WWD: output_port<=rs.
    - 29 HLT.
    - Any other func is a NOP.
  - 4 LWD: rt=M[rs+simm].
  - 5 SWD: M[rs+simm]=rt.
  - 6 BNE, 7 BEQ: compare rs with rt; if taken PC=PC+1+simm.
  - 8 JMP: PC={PC[WORD_SIZE-1:12],tgt}.
  - 9-15: NOP.
- Arithmetic: all modulo 2^WORD_SIZE; no flags.
- FSM states:
  - IF:
    - Outputs: readM=1, address=PC.
    - Stays in IF while inputReady=0.
    - On the edge with inputReady=1: IR<=data_in[15:0], go EX.
  - EX:
    - Reads registers and computes the ALU result.
    - For non-memory ops the same edge writes the destination register, updates PC (PC+1 or branch/jump target), increments num_inst and goes to IF.
    - LWD/SWD: latch the effective address, go MEM.
    - HLT: increment num_inst, go HALT; PC is unchanged.
  - MEM:
    - LWD outputs: readM=1, address=EA.
    - SWD outputs: writeM=1, address=EA, data_out=rt.
    - Holds while inputReady=0.
    - On inputReady=1: LWD writes rt<=data_in; PC<=PC+1; num_inst++; go IF.
  - HALT: halted=1, readM=writeM=0; exits only via reset.
- readM and writeM are never high together.
  - Request signals are combinational from state and stay stable until the completing edge.
  - address/data_out are stable for the whole request.
- Latency with zero wait states:
  - ALU, branch, jump, WWD: 2 clocks.
  - LWD/SWD: 3 clocks.
  - Each memory wait cycle adds 1 clock.
- inputReady while no request is pending is ignored.
- PC wraps modulo 2^WORD_SIZE.
- num_inst wraps from all-ones to 0.
- A write to rt/rd in EX is visible to the next instruction's EX.

Test Plan:
- Reset, then memory returns ADI r1,r0,5 / LHI r2,0x12 / ADD r3,r1,r2 / WWD r3 with zero wait states -> output_port=0x1205 after 8 clocks; num_inst=4; PC=4.
- SWD r1→[r0+0x10] then LWD r2←[r0+0x10] with 3 wait cycles on each access -> write cycle shows address=0x10, data_out=5 held for 4 clocks; r2=5; each memory op takes 3+3+3=9 clocks total (fetch wait and access wait included).
- BEQ r0,r0,-1 at PC=7 -> next fetch address 7 (tight loop), num_inst increments every 2 clocks; BNE r0,r0,+3 -> not taken, PC=8.
- JMP tgt=0x0A5 at PC=0x1003 with WORD_SIZE=16 -> next fetch address 0x10A5; SHR on r=0x8000 -> 0xC000; TCP on 1 -> 0xFFFF.
- HLT -> halted=1 next edge, readM stays 0 for 20 clocks, num_inst frozen; reset_n=0 one edge -> halted=0, fetch from RESET_PC.
- Reset asserted during a MEM write wait -> writeM=0 while reset low, memory not written (inputReady pulse ignored), registers=0, restart fetch at RESET_PC; repeat regression with WORD_SIZE=32 and simm sign-extension checked (ADI imm=0x80 → 0xFFFFFF80).

Source files
------------

// File: rtl/multicycle_cpu.sv
// multicycle_cpu: multi-cycle 16-bit-ISA CPU core with a generalised datapath width.
// Each instruction goes IF -> EX (-> MEM) -> IF over one shared memory port, with a
// readM/writeM/inputReady handshake that allows any number of wait states per access.
// WORD_SIZE must be >= 16 and NUM_REGS must be 2 or 4.
//
// Ports:
//   clk          rising-edge clock
//   reset_n      synchronous active-low reset
//   readM        memory read request
//   writeM       memory write request
//   address      memory address for the current request
//   data_out     store data (0 when writeM=0)
//   data_in      read data, valid on the edge where inputReady=1
//   inputReady   memory completes the current request this edge
//   num_inst     retired-instruction count
//   output_port  last value written by WWD
//   halted       core is in the HALT state
module multicycle_cpu #(
    parameter int unsigned          WORD_SIZE = 16,
    parameter int unsigned          NUM_REGS  = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = '0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    output logic                 readM,
    output logic                 writeM,
    output logic [WORD_SIZE-1:0] address,
    output logic [WORD_SIZE-1:0] data_out,
    input  logic [WORD_SIZE-1:0] data_in,
    input  logic                 inputReady,
    output logic [WORD_SIZE-1:0] num_inst,
    output logic [WORD_SIZE-1:0] output_port,
    output logic                 halted
);

    localparam int unsigned RegIdxW = (NUM_REGS > 2) ? 2 : 1;

    localparam logic [3:0] OpAdi = 4'd0;
    localparam logic [3:0] OpOri = 4'd1;
    localparam logic [3:0] OpLhi = 4'd2;
    localparam logic [3:0] OpRty = 4'd3;
    localparam logic [3:0] OpLwd = 4'd4;
    localparam logic [3:0] OpSwd = 4'd5;
    localparam logic [3:0] OpBne = 4'd6;
    localparam logic [3:0] OpBeq = 4'd7;
    localparam logic [3:0] OpJmp = 4'd8;

    localparam logic [5:0] FnAdd = 6'd0;
    localparam logic [5:0] FnSub = 6'd1;
    localparam logic [5:0] FnAnd = 6'd2;
    localparam logic [5:0] FnOrr = 6'd3;
    localparam logic [5:0] FnNot = 6'd4;
    localparam logic [5:0] FnTcp = 6'd5;
    localparam logic [5:0] FnShl = 6'd6;
    localparam logic [5:0] FnShr = 6'd7;
    localparam logic [5:0] FnWwd = 6'd28;
    localparam logic [5:0] FnHlt = 6'd29;

    typedef enum logic [1:0] {StIf, StEx, StMem, StHalt} state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] pc_q, pc_d;
    logic [15:0]          ir_q, ir_d;
    logic [WORD_SIZE-1:0] ea_q, ea_d;
    logic [WORD_SIZE-1:0] num_q, num_d;
    logic [WORD_SIZE-1:0] out_q, out_d;
    logic [WORD_SIZE-1:0] rf_q [NUM_REGS];

    // Register-file write port, driven from EX (ALU ops) or MEM (LWD).
    logic                 rf_we;
    logic [RegIdxW-1:0]   rf_widx;
    logic [WORD_SIZE-1:0] rf_wdata;

    // Instruction fields
    logic [3:0]           op;
    logic [5:0]           func;
    logic [7:0]           imm8;
    logic [RegIdxW-1:0]   rs_idx, rt_idx, rd_idx;
    logic [WORD_SIZE-1:0] rs_val, rt_val, simm, zimm, pc_inc;

    assign op     = ir_q[15:12];
    assign func   = ir_q[5:0];
    assign imm8   = ir_q[7:0];
    assign rs_idx = ir_q[10 +: RegIdxW];
    assign rt_idx = ir_q[8 +: RegIdxW];
    assign rd_idx = ir_q[6 +: RegIdxW];
    assign rs_val = rf_q[rs_idx];
    assign rt_val = rf_q[rt_idx];
    assign simm   = {{(WORD_SIZE-8){imm8[7]}}, imm8};
    assign zimm   = {{(WORD_SIZE-8){1'b0}}, imm8};
    assign pc_inc = pc_q + WORD_SIZE'(1);

    // Next-state and architectural updates
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        ir_d     = ir_q;
        ea_d     = ea_q;
        num_d    = num_q;
        out_d    = out_q;
        rf_we    = 1'b0;
        rf_widx  = rt_idx;
        rf_wdata = '0;

        unique case (state_q)
            StIf: begin
                if (inputReady) begin
                    ir_d    = data_in[15:0];
                    state_d = StEx;
                end
            end

            StEx: begin
                // Default: retire this edge and fetch the next sequential instruction.
                pc_d    = pc_inc;
                num_d   = num_q + WORD_SIZE'(1);
                state_d = StIf;
                case (op)
                    OpAdi: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs_val + simm;
                    end
                    OpOri: begin
                        rf_we    = 1'b1;
                        rf_wdata = rs_val | zimm;
                    end
                    OpLhi: begin
                        rf_we    = 1'b1;
                        rf_wdata = zimm << 8;
                    end
                    OpRty: begin
                        rf_widx = rd_idx;
                        case (func)
                            FnAdd: begin rf_we = 1'b1; rf_wdata = rs_val + rt_val; end
                            FnSub: begin rf_we = 1'b1; rf_wdata = rs_val - rt_val; end
                            FnAnd: begin rf_we = 1'b1; rf_wdata = rs_val & rt_val; end
                            FnOrr: begin rf_we = 1'b1; rf_wdata = rs_val | rt_val; end
                            FnNot: begin rf_we = 1'b1; rf_wdata = ~rs_val; end
                            FnTcp: begin rf_we = 1'b1; rf_wdata = '0 - rs_val; end
                            FnShl: begin rf_we = 1'b1; rf_wdata = rs_val << 1; end
                            FnShr: begin
                                rf_we    = 1'b1;
                                rf_wdata = {rs_val[WORD_SIZE-1], rs_val[WORD_SIZE-1:1]};
                            end
                            FnWwd: out_d = rs_val;
                            FnHlt: begin
                                pc_d    = pc_q;
                                state_d = StHalt;
                            end
                            default: ;
                        endcase
                    end
                    OpLwd, OpSwd: begin
                        // Retirement is deferred to the edge that completes the access.
                        ea_d    = rs_val + simm;
                        pc_d    = pc_q;
                        num_d   = num_q;
                        state_d = StMem;
                    end
                    OpBne: if (rs_val != rt_val) pc_d = pc_inc + simm;
                    OpBeq: if (rs_val == rt_val) pc_d = pc_inc + simm;
                    OpJmp: pc_d = {pc_q[WORD_SIZE-1:12], ir_q[11:0]};
                    default: ;
                endcase
            end

            StMem: begin
                if (inputReady) begin
                    if (op == OpLwd) begin
                        rf_we    = 1'b1;
                        rf_wdata = data_in;
                    end
                    pc_d    = pc_inc;
                    num_d   = num_q + WORD_SIZE'(1);
                    state_d = StIf;
                end
            end

            StHalt: ;

            default: state_d = StIf;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= StIf;
            pc_q    <= RESET_PC;
            ir_q    <= '0;
            ea_q    <= '0;
            num_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            ea_q    <= ea_d;
            num_q   <= num_d;
            out_q   <= out_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
        end else if (rf_we) begin
            rf_q[rf_widx] <= rf_wdata;
        end
    end

    // Memory requests depend only on state, so they hold until the completing edge;
    // reset gates them off immediately so an in-flight access is abandoned.
    always_comb begin
        readM    = 1'b0;
        writeM   = 1'b0;
        address  = '0;
        data_out = '0;
        if (reset_n) begin
            unique case (state_q)
                StIf: begin
                    readM   = 1'b1;
                    address = pc_q;
                end
                StMem: begin
                    address = ea_q;
                    if (op == OpSwd) begin
                        writeM   = 1'b1;
                        data_out = rt_val;
                    end else begin
                        readM = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign num_inst    = num_q;
    assign output_port = out_q;
    assign halted      = (state_q == StHalt);

endmodule

// File: tb/tb_multicycle_cpu.sv
// tb_multicycle_cpu: directed self-checking bench for multicycle_cpu.
// A 16-bit core runs against a memory model with programmable wait states; a 32-bit
// core runs a short load/store/sign-extension program against a zero-wait memory.
module tb_multicycle_cpu;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;

    // 16-bit instance
    logic        readM, writeM, halted;
    logic        inputReady = 1'b0;
    logic [15:0] address, data_out, num_inst, output_port;
    logic [15:0] data_in = '0;
    logic [15:0] mem [65536];

    // 32-bit instance
    logic        readM_w, writeM_w, halted_w;
    logic        inputReady_w = 1'b0;
    logic [31:0] address_w, data_out_w, num_inst_w, output_port_w;
    logic [31:0] data_in_w = '0;
    logic [31:0] mem_w [256];
    logic        mem_w_loaded = 1'b0;

    int   waits = 0;
    int   wait_cnt = 0;
    logic force_ready = 1'b0;
    int   phase = 1;
    int   loaded_phase = 0;
    logic saw_req;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_cpu #(
        .WORD_SIZE (16),
        .NUM_REGS  (4),
        .RESET_PC  (16'h0000)
    ) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .readM       (readM),
        .writeM      (writeM),
        .address     (address),
        .data_out    (data_out),
        .data_in     (data_in),
        .inputReady  (inputReady),
        .num_inst    (num_inst),
        .output_port (output_port),
        .halted      (halted)
    );

    multicycle_cpu #(
        .WORD_SIZE (32),
        .NUM_REGS  (4),
        .RESET_PC  (32'h0)
    ) u_dut_w (
        .clk         (clk),
        .reset_n     (reset_n),
        .readM       (readM_w),
        .writeM      (writeM_w),
        .address     (address_w),
        .data_out    (data_out_w),
        .data_in     (data_in_w),
        .inputReady  (inputReady_w),
        .num_inst    (num_inst_w),
        .output_port (output_port_w),
        .halted      (halted_w)
    );

    // Memory image for each phase; only the responder process writes mem.
    task automatic load_phase(input int p);
        case (p)
            1: begin
                for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
                mem[16'h0000] = 16'h0105; // ADI r1,r0,5
                mem[16'h0001] = 16'h2212; // LHI r2,0x12
                mem[16'h0002] = 16'h36C0; // ADD r3,r1,r2
                mem[16'h0003] = 16'h3C1C; // WWD r3
                mem[16'h0004] = 16'h5110; // SWD r1,[r0+0x10]
                mem[16'h0005] = 16'h4210; // LWD r2,[r0+0x10]
                mem[16'h0006] = 16'h381C; // WWD r2
                mem[16'h0007] = 16'h70FF; // BEQ r0,r0,-1
                mem[16'h0008] = 16'h8FFF; // JMP 0xFFF
                mem[16'h0FFF] = 16'h9000; // NOP
                mem[16'h1000] = 16'h2180; // LHI r1,0x80
                mem[16'h1001] = 16'h3487; // SHR r2,r1
                mem[16'h1002] = 16'h381C; // WWD r2
                mem[16'h1003] = 16'h80A5; // JMP 0x0A5
                mem[16'h10A5] = 16'h0301; // ADI r3,r0,1
                mem[16'h10A6] = 16'h3CC5; // TCP r3,r3
                mem[16'h10A7] = 16'h3C1C; // WWD r3
                mem[16'h10A8] = 16'h301D; // HLT
            end
            2: mem[16'h0007] = 16'h6003; // BNE r0,r0,+3
            3: begin
                mem[16'h0000] = 16'h0105; // ADI r1,r0,5
                mem[16'h0001] = 16'h5120; // SWD r1,[r0+0x20]
                mem[16'h0020] = 16'h0BAD;
            end
            4: begin
                mem[16'h0000] = 16'h1530; // ORI r1,r1,0x30
                mem[16'h0001] = 16'h341C; // WWD r1
            end
            default: ;
        endcase
    endtask

    // 16-bit memory: completes a request after `waits` stall cycles.
    always @(negedge clk) begin
        #1;
        if (phase != loaded_phase) begin
            load_phase(phase);
            loaded_phase = phase;
        end
        if (readM || writeM) begin
            if (wait_cnt >= waits) begin
                inputReady = 1'b1;
                wait_cnt   = 0;
                if (writeM) mem[address] = data_out;
            end else begin
                inputReady = 1'b0;
                wait_cnt++;
            end
            data_in = mem[address];
        end else begin
            inputReady = force_ready;
            wait_cnt   = 0;
            data_in    = '0;
        end
    end

    // 32-bit memory: zero wait states.
    always @(negedge clk) begin
        #1;
        if (!mem_w_loaded) begin
            for (int i = 0; i < 256; i++) mem_w[i] = 32'h0;
            mem_w[0] = 32'h0000_0180; // ADI r1,r0,0x80
            mem_w[1] = 32'h0000_5140; // SWD r1,[r0+0x40]
            mem_w[2] = 32'h0000_4240; // LWD r2,[r0+0x40]
            mem_w[3] = 32'h0000_381C; // WWD r2
            mem_w[4] = 32'h0000_301D; // HLT
            mem_w_loaded = 1'b1;
        end
        if (writeM_w) mem_w[address_w[7:0]] = data_out_w;
        data_in_w    = mem_w[address_w[7:0]];
        inputReady_w = readM_w | writeM_w;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then return on the following falling edge.
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        cyc(2);
        check_eq("rst_readM", readM, 0);
        check_eq("rst_addr", address, 0);
        check_eq("rst_num", num_inst, 0);
        check_eq("rst_out", output_port, 0);
        check_eq("rst_halted", halted, 0);
        reset_n = 1'b1;

        // Four ALU instructions, zero wait states, 2 clocks each
        cyc(8);
        check_eq("alu_out", output_port, 16'h1205);
        check_eq("alu_num", num_inst, 4);
        check_eq("alu_pc", address, 4);
        check_eq("alu_readM", readM, 1);

        // SWD then LWD with 3 wait cycles per access
        waits = 3;
        cyc(5);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) cyc(1);
            check_eq("swd_writeM", writeM, 1);
            check_eq("swd_readM", readM, 0);
            check_eq("swd_addr", address, 16'h0010);
            check_eq("swd_data", data_out, 16'h0005);
        end
        cyc(1);
        check_eq("swd_num", num_inst, 5);
        check_eq("swd_done_writeM", writeM, 0);
        check_eq("swd_mem", mem[16'h0010], 16'h0005);
        cyc(8);
        check_eq("lwd_num_early", num_inst, 5);
        cyc(1);
        check_eq("lwd_num", num_inst, 6);
        cyc(5);
        check_eq("lwd_out", output_port, 16'h0005);
        check_eq("lwd_num2", num_inst, 7);
        check_eq("lwd_pc", address, 7);

        // 32-bit core has finished its program by now
        check_eq("w32_out", output_port_w, 32'hFFFF_FF80);
        check_eq("w32_mem", mem_w[8'h40], 32'hFFFF_FF80);
        check_eq("w32_num", num_inst_w, 5);
        check_eq("w32_halted", halted_w, 1);

        // BEQ tight loop, then patch to a not-taken BNE
        waits = 0;
        cyc(2);
        check_eq("beq_pc1", address, 7);
        check_eq("beq_num1", num_inst, 8);
        cyc(2);
        check_eq("beq_pc2", address, 7);
        check_eq("beq_num2", num_inst, 9);
        phase = 2;
        cyc(2);
        check_eq("bne_pc", address, 8);
        check_eq("bne_num", num_inst, 10);

        // JMP, wrap into 0x1000 page, SHR, JMP with page kept, TCP
        cyc(2);
        check_eq("jmp1_pc", address, 16'h0FFF);
        cyc(2);
        check_eq("nop_pc", address, 16'h1000);
        cyc(6);
        check_eq("shr_out", output_port, 16'hC000);
        check_eq("shr_pc", address, 16'h1003);
        cyc(2);
        check_eq("jmp2_pc", address, 16'h10A5);
        cyc(6);
        check_eq("tcp_out", output_port, 16'hFFFF);
        check_eq("tcp_pc", address, 16'h10A8);
        check_eq("tcp_num", num_inst, 19);

        // HLT: no further requests, stray inputReady ignored
        cyc(1);
        check_eq("hlt_ex_halted", halted, 0);
        cyc(1);
        check_eq("hlt_halted", halted, 1);
        check_eq("hlt_num", num_inst, 20);
        force_ready = 1'b1;
        saw_req = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (readM || writeM) saw_req = 1'b1;
        end
        check_eq("hlt_no_req", saw_req, 0);
        check_eq("hlt_num_frozen", num_inst, 20);
        check_eq("hlt_still", halted, 1);
        force_ready = 1'b0;

        // One-edge reset leaves HALT and refetches from RESET_PC
        phase = 3;
        waits = 5;
        reset_n = 1'b0;
        cyc(1);
        check_eq("hrst_halted", halted, 0);
        check_eq("hrst_num", num_inst, 0);
        check_eq("hrst_out", output_port, 0);
        check_eq("hrst_readM", readM, 0);
        reset_n = 1'b1;
        #1;
        check_eq("hrst_fetch", readM, 1);
        check_eq("hrst_addr", address, 0);

        // Reset during a store wait abandons the store
        cyc(14);
        check_eq("mrst_writeM", writeM, 1);
        check_eq("mrst_addr", address, 16'h0020);
        cyc(2);
        check_eq("mrst_wait", writeM, 1);
        reset_n = 1'b0;
        force_ready = 1'b1;
        phase = 4;
        #1;
        check_eq("mrst_gate_w", writeM, 0);
        check_eq("mrst_gate_a", address, 0);
        check_eq("mrst_gate_d", data_out, 0);
        cyc(1);
        check_eq("mrst_mem", mem[16'h0020], 16'h0BAD);
        reset_n = 1'b1;
        force_ready = 1'b0;
        waits = 0;
        cyc(4);
        check_eq("mrst_regs", output_port, 16'h0030);
        check_eq("mrst_num", num_inst, 2);
        check_eq("mrst_pc", address, 2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
